// File: rtl/sevenseg_reader.sv
// Seven-segment line reader: synchronizes and debounces the segment lines, then decodes them to a hex digit.
// Optional decimal-point channel is enabled by defining SEVENSEG_READER_DP_EN.
module sevenseg_reader #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter bit          ACTIVE_LOW    = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] seg_in,
`ifdef SEVENSEG_READER_DP_EN
   input  logic       seg_dp,
   output logic       digit_dp,
`endif
   output logic [3:0] digit,
   output logic       pattern_err,
   output logic       digit_valid,
   input  logic       digit_ready,
   output logic       overrun
);

`ifdef SEVENSEG_READER_DP_EN
   localparam int W = 8;
`else
   localparam int W = 7;
`endif
   localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

   localparam logic [1:0] ST_SETTLE = 2'd0;
   localparam logic [1:0] ST_REPORT = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   logic [W-1:0] seg_raw;
   logic [W-1:0] sync1_q, sync2_q;
   logic [W-1:0] lit;
   logic [W-1:0] pat_q;
   logic [W-1:0] last_q, last_d;
   logic [7:0]   cnt_q, cnt_d;
   logic [1:0]   state_q, state_d;
   logic [3:0]   digit_q, digit_d;
   logic         err_q, err_d;
   logic         valid_q, valid_d;
   logic         overrun_q, overrun_d;
   logic         changed, qualified, accept;
   logic [4:0]   dec;

`ifdef SEVENSEG_READER_DP_EN
   logic dp_q, dp_d;
   assign seg_raw  = {seg_dp, seg_in};
   assign digit_dp = dp_q;
`else
   assign seg_raw = seg_in;
`endif

   function automatic logic [4:0] decode(input logic [6:0] p);
      case (p)
         7'h3F:   decode = 5'h00;
         7'h06:   decode = 5'h01;
         7'h5B:   decode = 5'h02;
         7'h4F:   decode = 5'h03;
         7'h66:   decode = 5'h04;
         7'h6D:   decode = 5'h05;
         7'h7D:   decode = 5'h06;
         7'h07:   decode = 5'h07;
         7'h7F:   decode = 5'h08;
         7'h6F:   decode = 5'h09;
         7'h77:   decode = 5'h0A;
         7'h7C:   decode = 5'h0B;
         7'h39:   decode = 5'h0C;
         7'h5E:   decode = 5'h0D;
         7'h79:   decode = 5'h0E;
         7'h71:   decode = 5'h0F;
         default: decode = 5'h10;
      endcase
   endfunction

   assign lit       = ACTIVE_LOW ? ~sync2_q : sync2_q;
   assign changed   = (lit != pat_q);
   assign qualified = (cnt_q == STABLE);
   assign accept    = valid_q && digit_ready;
   assign dec       = decode(pat_q[6:0]);
   assign cnt_d     = changed ? 8'd1 : (qualified ? cnt_q : cnt_q + 8'd1);

   // pat_q is the previous cycle's lit; cnt_q counts how long it has been held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         pat_q   <= '0;
         cnt_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments let every flop sample the pre-edge value, so the chain really is two stages.
         sync1_q <= seg_raw;
         sync2_q <= sync1_q;
         pat_q   <= lit;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, otherwise unassigned paths infer latches.
      state_d   = state_q;
      digit_d   = digit_q;
      err_d     = err_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      last_d    = last_q;
`ifdef SEVENSEG_READER_DP_EN
      dp_d      = dp_q;
`endif
      case (state_q)
         ST_SETTLE: begin
            if (qualified) begin
               if (pat_q == '0) begin
                  last_d  = '0;
                  state_d = ST_LOCKED;
               end else if (pat_q == last_q) begin
                  state_d = ST_LOCKED;
               end else begin
                  digit_d = dec[3:0];
                  err_d   = dec[4];
                  valid_d = 1'b1;
                  last_d  = pat_q;
`ifdef SEVENSEG_READER_DP_EN
                  dp_d    = pat_q[7];
`endif
                  state_d = ST_REPORT;
               end
            end
         end
         ST_REPORT: begin
            if (accept) begin
               valid_d = 1'b0;
               // Any doubt about what is on the lines sends us back to SETTLE for a fresh look.
               state_d = (qualified && !changed && pat_q == last_q) ? ST_LOCKED : ST_SETTLE;
            end else if (qualified && pat_q != '0 && pat_q != last_q) begin
               overrun_d = 1'b1;
               last_d    = pat_q;
            end
         end
         ST_LOCKED: begin
            if (changed) state_d = ST_SETTLE;
         end
         default: state_d = ST_SETTLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_SETTLE;
         digit_q   <= 4'd0;
         err_q     <= 1'b0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         last_q    <= '0;
`ifdef SEVENSEG_READER_DP_EN
         dp_q      <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         digit_q   <= digit_d;
         err_q     <= err_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         last_q    <= last_d;
`ifdef SEVENSEG_READER_DP_EN
         dp_q      <= dp_d;
`endif
      end
   end

   assign digit       = digit_q;
   assign pattern_err = err_q;
   assign digit_valid = valid_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_sevenseg_reader.sv
// Scoreboard bench for sevenseg_reader: stimulus pushes expected results, a monitor pops them on each handshake.
module tb_sevenseg_reader;
   localparam int S = 4;
   localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] seg_in;
   logic       digit_ready;
   logic [3:0] digit;
   logic       pattern_err;
   logic       digit_valid;
   logic       overrun;

   int checks = 0;
   int failures = 0;
   logic [4:0] exp_q[$];
   logic [4:0] mon_e;
   logic [6:0] model_last = 7'h00;
   logic [6:0] cur_lit = 7'h00;
   bit bp_en = 1'b0;
   int low_run = 0;
   int n;

   always #5 clk = ~clk;

   sevenseg_reader #(.STABLE_CYCLES(S), .ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .digit(digit), .pattern_err(pattern_err),
      .digit_valid(digit_valid), .digit_ready(digit_ready), .overrun(overrun)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference decode: position of the lit pattern in the glyph table, else error with digit 0.
   function automatic logic [4:0] model_decode(input logic [6:0] l);
      for (int i = 0; i < 16; i++)
         if (GLYPH[i] == l) return {1'b0, 4'(i)};
      return 5'h10;
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
      if (bp_en) begin
         if (low_run >= 3 || $urandom_range(0, 1) == 1) begin
            digit_ready = 1'b1;
            low_run = 0;
         end else begin
            digit_ready = 1'b0;
            low_run++;
         end
      end
   endtask

   task automatic hold(input logic [6:0] l, input int len);
      seg_in = ~l;
      cur_lit = l;
      repeat (len) tick();
   endtask

   // A run of len cycles qualifies when len >= S; a qualifying nonblank glyph differing from the
   // last reported one is reported, a qualifying blank forgets the last report.
   task automatic run_model(input logic [6:0] l, input int len);
      if (len >= S) begin
         if (l == 7'h00) model_last = 7'h00;
         else if (l != model_last) begin
            exp_q.push_back(model_decode(l));
            model_last = l;
         end
      end
      hold(l, len);
   endtask

   task automatic random_runs(input int count, input int long_min, input int long_max);
      for (int r = 0; r < count; r++) begin
         logic [6:0] v;
         int len;
         int kind;
         do begin
            kind = $urandom_range(0, 9);
            if (kind < 6 || kind > 7) v = GLYPH[$urandom_range(0, 15)];
            else if (kind == 6)       v = 7'h00;
            else                      v = 7'($urandom);
         end while (v == cur_lit);
         if ($urandom_range(0, 9) < 3) len = $urandom_range(1, S - 1);
         else                          len = $urandom_range(long_min, long_max);
         run_model(v, len);
      end
   endtask

   // First posedge captures the pattern; returns edges after that until digit_valid is seen.
   task automatic edges_to_valid(output int cnt);
      cnt = 0;
      @(posedge clk);
      while (cnt < 20) begin
         @(posedge clk);
         cnt++;
         #1;
         if (digit_valid) break;
      end
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n && digit_valid && digit_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result: got digit=%0h err=%0b, expected no result", digit, pattern_err);
         end else begin
            mon_e = exp_q.pop_front();
            check("result_digit", 32'(digit), 32'(mon_e[3:0]));
            check("result_err", 32'(pattern_err), 32'(mon_e[4]));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      seg_in = 7'h7F;
      digit_ready = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check("reset_digit", 32'(digit), 32'h0);
      check("reset_err", 32'(pattern_err), 32'h0);
      check("reset_valid", 32'(digit_valid), 32'h0);
      check("reset_overrun", 32'(overrun), 32'h0);
      rst_n = 1'b1;
      hold(7'h00, 10);

      // Latency and single pulse for a held '0'
      exp_q.push_back(5'h00);
      seg_in = 7'h40;
      cur_lit = 7'h3F;
      edges_to_valid(n);
      check("latency", 32'(n), 32'(S + 2));
      tick();
      check("valid_pulse", 32'(digit_valid), 32'h0);
      repeat (15) tick();
      check("t1_drain", 32'(exp_q.size()), 32'h0);

      // All sixteen glyphs in order
      hold(7'h00, 10);
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back({1'b0, 4'(i)});
         hold(GLYPH[i], 8);
      end
      hold(GLYPH[15], 4);
      check("glyphs_drain", 32'(exp_q.size()), 32'h0);
      check("glyphs_overrun", 32'(overrun), 32'h0);

      // Toggling faster than the filter, then settle on '1'
      for (int k = 0; k < 17; k++) hold((k % 2 == 0) ? 7'h3F : 7'h06, 3);
      exp_q.push_back(5'h01);
      hold(7'h06, 15);
      check("toggle_drain", 32'(exp_q.size()), 32'h0);

      // Blank between identical glyphs re-arms the report; illegal glyph
      exp_q.push_back(5'h00);
      hold(7'h3F, 10);
      hold(7'h00, 10);
      exp_q.push_back(5'h00);
      hold(7'h3F, 10);
      exp_q.push_back(5'h10);
      hold(7'h01, 10);
      hold(7'h00, 12);
      check("blank_drain", 32'(exp_q.size()), 32'h0);
      model_last = 7'h00;

      // Random runs, consumer always ready
      random_runs(60, S + 3, S + 10);
      run_model(7'h00, 20);
      check("rand_drain", 32'(exp_q.size()), 32'h0);
      check("rand_overrun", 32'(overrun), 32'h0);

      // Random runs with short consumer stalls
      bp_en = 1'b1;
      random_runs(40, S + 10, S + 16);
      run_model(7'h00, 20);
      bp_en = 1'b0;
      digit_ready = 1'b1;
      hold(7'h00, 5);
      check("bp_drain", 32'(exp_q.size()), 32'h0);
      check("bp_overrun", 32'(overrun), 32'h0);

      // Overrun: new glyph qualifies while the old result is still held
      digit_ready = 1'b0;
      exp_q.push_back(5'h00);
      hold(7'h3F, 10);
      check("ovr_valid_before", 32'(digit_valid), 32'h1);
      hold(7'h06, 10);
      check("ovr_flag", 32'(overrun), 32'h1);
      check("ovr_valid_held", 32'(digit_valid), 32'h1);
      check("ovr_digit_held", 32'(digit), 32'h0);
      digit_ready = 1'b1;
      hold(7'h06, 10);
      check("ovr_drain", 32'(exp_q.size()), 32'h0);
      check("ovr_sticky", 32'(overrun), 32'h1);

      // Asynchronous reset while a result is pending
      digit_ready = 1'b0;
      exp_q.push_back(5'h00);
      hold(7'h3F, 10);
      check("rst_valid_before", 32'(digit_valid), 32'h1);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_digit", 32'(digit), 32'h0);
      check("rst_valid", 32'(digit_valid), 32'h0);
      check("rst_overrun", 32'(overrun), 32'h0);
      check("rst_err", 32'(pattern_err), 32'h0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      edges_to_valid(n);
      check("rst_relatency", 32'(n), 32'(S + 2));
      digit_ready = 1'b1;
      hold(7'h3F, 10);
      check("rst_drain", 32'(exp_q.size()), 32'h0);
      hold(7'h00, 10);

      check("final_drain", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sevenseg_reader.md
Name: sevenseg_reader

Overview:
- Receive-side counterpart of the board's seven-segment driver.
- Samples the seven segment lines (a–g) driven onto the display net and waits for the pattern to settle.
- Decodes the settled pattern back to a hex digit and presents it on a valid/ready output.
- Used for loopback self-test of display logic and for reading segment outputs from an external board.

Parameters:
- STABLE_CYCLES, 4: consecutive identical synchronized samples required before a pattern qualifies. Legal range 1..255.
- ACTIVE_LOW, 1: 1 means a segment input at 0 is lit (common-anode, the board default); 0 means a segment input at 1 is lit.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- seg_in, in, 7: segment lines, {g,f,e,d,c,b,a}, bit0=a. Asynchronous to clk.
- digit, out, 4: decoded hex value 0x0–0xF.
- pattern_err, out, 1: qualified pattern was not a legal hex glyph; digit=0.
- digit_valid, out, 1: output holds an unconsumed result.
- digit_ready, in, 1: consumer accepts when high with digit_valid.
- overrun, out, 1: sticky; a qualified new pattern was dropped because the output was still full.

Behaviour:
- Reset (rst_n low, asynchronous): digit=0, pattern_err=0, digit_valid=0, overrun=0. Sync flops, stability counter and last-reported pattern clear to 0 (0 means blank). FSM goes to SETTLE. Reset mid-handshake discards the pending result.
- Input path:
  - 2-flop synchronizer on all 7 bits.
  - Normalize to lit-high: lit = ACTIVE_LOW ? ~sync : sync.
- Stability counter (8 bit):
  - Reloads to 1 when lit differs from the previous cycle's lit.
  - Otherwise increments, saturating at STABLE_CYCLES.
  - Pattern qualifies on the cycle the counter reaches STABLE_CYCLES.
- Decode table (lit, hex -> digit): 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9, 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F. Any other nonzero value -> pattern_err=1, digit=0.
- FSM:
  - SETTLE: wait for qualification.
    - Qualified lit == 0 (blank): last-reported <= 0, go to LOCKED, no report.
    - Qualified lit == last-reported: go to LOCKED, no report.
    - Otherwise: load digit/pattern_err, set digit_valid, last-reported <= lit, go to REPORT.
  - REPORT: hold digit, pattern_err and digit_valid stable until digit_valid && digit_ready.
    - On acceptance: clear digit_valid next edge. Go to LOCKED if lit is unchanged since qualification, else SETTLE.
    - If a different nonblank pattern qualifies while still waiting: set overrun, keep the old output, and update last-reported so the dropped pattern is not re-reported.
  - LOCKED: any change of lit -> SETTLE.
- Latency: a pattern held constant on seg_in asserts digit_valid STABLE_CYCLES+2 clk edges after it is first captured by the first sync flop.
- Simultaneous events: acceptance and a new qualification in the same cycle → acceptance wins. The new pattern is evaluated in SETTLE on the next cycle (counter is not reset), so it is reported, not overrun.
- overrun clears only on reset.
- Back-to-back results: digit_valid may go low for only one cycle between them.
- digit_valid never depends combinationally on digit_ready.

Optional Feature:
- Macro: SEVENSEG_READER_DP_EN.
- Defined:
  - Adds input seg_dp (1 bit, same polarity rule as seg_in) and output digit_dp (1 bit, reset 0).
  - seg_dp is synchronized with seg_in and included in change detection and in the last-reported compare.
  - digit_dp is captured alongside digit.
  - The blank check covers all 8 bits.
- Undefined: neither port exists; behaviour is exactly as described above.

Test Plan:
- ACTIVE_LOW=1, STABLE_CYCLES=4. Hold seg_in=7'h40 (a–f driven 0, g driven 1) with digit_ready=1 → digit_valid rises 6 edges after first capture, digit=0, pattern_err=0, one-cycle pulse, no repeat while the input is held.
- Step through the 16 table glyphs (inverted), each held 8 cycles, ready=1 → digits 0..F in order, 16 valid pulses, overrun=0.
- Toggle seg_in between 7'h40 and 7'h79 every 3 cycles for 50 cycles, then hold 7'h79 → no result during toggling, then one result digit=1.
- Lit pattern 0x3F, ready=0; then switch to 0x06 held 10 cycles → digit stays 0 with digit_valid=1, overrun=1. Raising ready gives one acceptance and no result for 1.
- Lit 0x3F reported, then blank 0x00 for 10 cycles, then 0x3F again → second result digit=0. Lit 0x01 → digit=0, pattern_err=1.
- Pull rst_n low for 1 cycle while digit_valid=1 (asynchronous, mid-cycle) → all outputs 0 immediately. The held pattern is reported again STABLE_CYCLES+2 edges after release.
